// File: rtl/imem_loader_if.sv
// Byte-stream, instruction-memory write port and status bundle of the program loader.
// The master side feeds the stream; the slave side (the loader) writes memory and reports status.
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  logic              start;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata, core_rst, busy, done, err
  );

  modport slave (
    input  start, rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata, core_rst, busy, done, err
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian word stream into instruction memory while
// holding the core in reset until a load completes successfully.
module imem_loader #(
  parameter int ADDR_W = 8
) (
  input logic         clk,
  input logic         rst,
  imem_loader_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int IDX_W = ADDR_W + 1;

  typedef enum logic [2:0] {
    IDLE,
    LEN0,
    LEN1,
    DATA,
    WRITE,
    DONE,
    ERR
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [15:0]      r_len;
  logic [IDX_W-1:0] r_idx;
  logic [1:0]       r_cnt;
  logic [31:0]      r_word;

  logic             w_rx_ready;
  logic             w_we;
  logic             w_busy;
  logic             w_done;
  logic             w_err;
  logic             w_core_rst;
  logic             w_accept;
  logic             w_start_load;
  logic [15:0]      w_len_full;
  logic [IDX_W-1:0] w_idx_inc;

  assign w_accept     = bus.rx_valid && w_rx_ready;
  assign w_start_load = bus.start && (r_state == IDLE || r_state == DONE || r_state == ERR);
  assign w_len_full   = {bus.rx_data, r_len[7:0]};
  assign w_idx_inc    = r_idx + IDX_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    w_next     = r_state;
    w_rx_ready = 1'b0;
    w_we       = 1'b0;
    w_busy     = 1'b0;
    w_done     = 1'b0;
    w_err      = 1'b0;
    w_core_rst = 1'b1;
    unique case (r_state)
      IDLE: if (bus.start) w_next = LEN0;
      LEN0: begin
        w_rx_ready = 1'b1;
        w_busy     = 1'b1;
        if (w_accept) w_next = LEN1;
      end
      LEN1: begin
        w_rx_ready = 1'b1;
        w_busy     = 1'b1;
        if (w_accept) begin
          if (w_len_full == 16'd0)                   w_next = DONE;
          else if ({16'd0, w_len_full} > 32'(DEPTH)) w_next = ERR;
          else                                       w_next = DATA;
        end
      end
      DATA: begin
        w_rx_ready = 1'b1;
        w_busy     = 1'b1;
        if (w_accept && r_cnt == 2'd3) w_next = WRITE;
      end
      WRITE: begin
        w_we   = 1'b1;
        w_busy = 1'b1;
        if (32'(w_idx_inc) == {16'd0, r_len}) w_next = DONE;
        else                                  w_next = DATA;
      end
      DONE: begin
        w_done     = 1'b1;
        w_core_rst = 1'b0;
        if (bus.start) w_next = LEN0;
      end
      ERR: begin
        w_err = 1'b1;
        if (bus.start) w_next = LEN0;
      end
      default: w_next = IDLE;
    endcase
  end

  // Datapath: length capture, little-endian word assembly and word index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len  <= '0;
      r_idx  <= '0;
      r_cnt  <= '0;
      r_word <= '0;
    end else if (w_start_load) begin
      r_idx <= '0;
      r_cnt <= '0;
    end else begin
      unique case (r_state)
        LEN0: if (w_accept) r_len[7:0]  <= bus.rx_data;
        LEN1: if (w_accept) r_len[15:8] <= bus.rx_data;
        DATA: if (w_accept) begin
          r_word <= {bus.rx_data, r_word[31:8]};
          r_cnt  <= r_cnt + 2'd1;
        end
        WRITE:   r_idx <= w_idx_inc;
        default: ;
      endcase
    end
  end

  assign bus.rx_ready   = w_rx_ready;
  assign bus.imem_we    = w_we;
  assign bus.imem_addr  = r_idx[ADDR_W-1:0];
  assign bus.imem_wdata = r_word;
  assign bus.busy       = w_busy;
  assign bus.done       = w_done;
  assign bus.err        = w_err;
  assign bus.core_rst   = w_core_rst;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized scoreboard bench for imem_loader: expected memory writes are queued per load
// and a separate monitor compares every observed write strobe against that queue.
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial forever #5 clk = ~clk;

  wr_t         exp_q[$];
  logic [31:0] load_words[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc      = 0;
  bit          prev_we  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every write strobe must match the head of the expected-write queue.
  initial forever begin
    wr_t e;
    @(negedge clk);
    if (bus.imem_we === 1'b1) begin
      check("we_one_cycle", 64'(prev_we), 64'(0));
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write (t=%0t)",
                 bus.imem_addr, bus.imem_wdata, $time);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", 64'(bus.imem_addr), 64'(e.addr));
        check("write_data", 64'(bus.imem_wdata), 64'(e.data));
      end
    end
    prev_we = (bus.imem_we === 1'b1);
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rx_ready"}, 64'(bus.rx_ready), 64'(0));
    check({tag, "_imem_we"}, 64'(bus.imem_we), 64'(0));
    check({tag, "_imem_addr"}, 64'(bus.imem_addr), 64'(0));
    check({tag, "_imem_wdata"}, 64'(bus.imem_wdata), 64'(0));
    check({tag, "_busy"}, 64'(bus.busy), 64'(0));
    check({tag, "_done"}, 64'(bus.done), 64'(0));
    check({tag, "_err"}, 64'(bus.err), 64'(0));
    check({tag, "_core_rst"}, 64'(bus.core_rst), 64'(1));
  endtask

  // All stimulus tasks start and return 1 time unit after a rising edge.
  task automatic do_start();
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_gap);
    int  gap;
    bit  acc;
    gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
    repeat (gap) begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      @(posedge clk);
      #1;
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      acc = bus.rx_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      if (t > 20) begin
        check("accept_timeout", 64'(acc), 64'(1));
        break;
      end
    end
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
  endtask

  // Reference: a load of n words writes words[i] at address i when 0 < n <= DEPTH,
  // ends in DONE for n <= DEPTH and in ERR otherwise.
  task automatic run_load(input int n, input int max_gap, input int start_at, input bit timed);
    int s;
    int t;
    int bi;
    logic [15:0] len;
    len = 16'(n);
    bi  = 0;
    if (n <= DEPTH)
      for (int i = 0; i < n; i++) exp_q.push_back('{addr: ADDR_W'(i), data: load_words[i]});
    do_start();
    s = cyc;
    check("start_busy", 64'(bus.busy), 64'(1));
    check("start_core_rst", 64'(bus.core_rst), 64'(1));
    check("start_done_clr", 64'({bus.done, bus.err}), 64'(0));
    send_byte(len[7:0], max_gap);
    send_byte(len[15:8], max_gap);
    if (n <= DEPTH) begin
      for (int w = 0; w < n; w++) begin
        for (int b = 0; b < 4; b++) begin
          if (bi == start_at) bus.start = 1'b1;
          send_byte(load_words[w][8*b +: 8], max_gap);
          bus.start = 1'b0;
          bi++;
        end
      end
    end
    t = 0;
    while (!(bus.done === 1'b1 || bus.err === 1'b1) && t < 50) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (n <= DEPTH) begin
      check("end_done", 64'(bus.done), 64'(1));
      check("end_err", 64'(bus.err), 64'(0));
      check("end_core_rst", 64'(bus.core_rst), 64'(0));
    end else begin
      check("end_err", 64'(bus.err), 64'(1));
      check("end_done", 64'(bus.done), 64'(0));
      check("end_core_rst", 64'(bus.core_rst), 64'(1));
      check("end_rx_ready", 64'(bus.rx_ready), 64'(0));
    end
    check("end_busy", 64'(bus.busy), 64'(0));
    if (timed) check("done_latency", 64'(cyc - s), 64'(12));
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));
  endtask

  initial begin
    int n;
    bus.start    = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    #2;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    repeat (3) @(posedge clk);
    #1;
    check("idle_core_rst", 64'(bus.core_rst), 64'(1));
    check("idle_busy", 64'(bus.busy), 64'(0));

    // Two-word reference program at full rate.
    load_words = '{32'h0000_0013, 32'h0010_0093};
    run_load(2, 0, -1, 1'b1);

    // Empty program.
    load_words = '{};
    run_load(0, 0, -1, 1'b0);

    // Over-length program rejected, then a valid load.
    run_load(257, 0, -1, 1'b0);
    load_words = '{};
    for (int i = 0; i < 3; i++) load_words.push_back($urandom);
    run_load(3, 0, -1, 1'b0);

    // Same three words with random rx_valid gaps.
    run_load(3, 3, -1, 1'b0);

    // Start pulsed during DATA is ignored.
    run_load(3, 0, 6, 1'b0);

    // Reset after two data bytes of the first word.
    load_words = '{};
    for (int i = 0; i < 2; i++) load_words.push_back($urandom | 32'h0000_0101);
    do_start();
    send_byte(8'd2, 0);
    send_byte(8'd0, 0);
    send_byte(load_words[0][7:0], 0);
    send_byte(load_words[0][15:8], 0);
    #2 rst = 1'b1;
    #1;
    check_reset_outputs("midload_rst");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    repeat (10) @(posedge clk);
    #1;
    check("post_rst_core_rst", 64'(bus.core_rst), 64'(1));
    check("post_rst_done", 64'(bus.done), 64'(0));
    run_load(2, 1, -1, 1'b0);

    // Random lengths, gaps and stray start pulses.
    for (int k = 0; k < 6; k++) begin
      n = int'($urandom_range(6, 1));
      load_words = '{};
      for (int i = 0; i < n; i++) load_words.push_back($urandom);
      run_load(n, int'($urandom_range(2, 0)), int'($urandom_range(4 * n - 1, 0)), 1'b0);
    end

    // Full-depth program: last write lands on DEPTH-1.
    load_words = '{};
    for (int i = 0; i < DEPTH; i++) load_words.push_back($urandom);
    run_load(DEPTH, 0, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
